// File: rtl/astro_genius_pkg.sv
// Shared AstroGenius types: command decoder FSM states, command packing {tiro, mira[2:0]}
// and helpers that validate and encode the one-hot aim field.
package astro_genius_pkg;

    typedef enum logic [3:0] {
        OCIOSO         = 4'd0,
        ESTABILIZANDO  = 4'd1,
        CAPTURA        = 4'd2,
        ESPERA_SOLTURA = 4'd3
    } estado_t;

    localparam int         CMD_LARG  = 4;
    localparam int         MIRA_LARG = 3;
    localparam logic [2:0] MIRA_MAX  = 3'd4;

    typedef struct packed {
        logic                 tiro;
        logic [MIRA_LARG-1:0] mira;
    } comando_t;

    // The aim field is accepted only when exactly one bit is set.
    function automatic logic mira_valida(input logic [4:0] m);
        return (m != 5'd0) && ((m & (m - 5'd1)) == 5'd0);
    endfunction

    function automatic logic [2:0] indice_mira(input logic [4:0] m);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i <= int'(MIRA_MAX); i++) begin
            if (m[i]) begin
                idx = 3'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/fifo_comandos.sv
// First-word-fall-through command FIFO; depth must be a power of two so the
// pointers wrap naturally. A push while full is accepted only together with a pop.
module fifo_comandos #(
    parameter int PROF = 4,
    parameter int LARG = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            push,
    input  logic            pop,
    input  logic [LARG-1:0] dado_escrita,
    output logic [LARG-1:0] dado_leitura,
    output logic            cheia,
    output logic            vazia,
    output logic            descarte
);

    localparam int PW = $clog2(PROF);
    localparam int CW = $clog2(PROF + 1);

    logic [LARG-1:0] mem_r [PROF];
    logic [PW-1:0]   rd_ptr_r;
    logic [PW-1:0]   wr_ptr_r;
    logic [CW-1:0]   cont_r;
    logic            pop_ef_s;
    logic            push_ef_s;

    assign vazia     = (cont_r == CW'(0));
    assign cheia     = (cont_r == CW'(PROF));
    assign pop_ef_s  = pop && !vazia;
    assign push_ef_s = push && (!cheia || pop_ef_s);
    assign descarte  = push && !push_ef_s;

    assign dado_leitura = vazia ? {LARG{1'b0}} : mem_r[rd_ptr_r];

    // Storage, pointers and occupancy count.
    always_ff @(posedge clock) begin
        if (!reset) begin
            rd_ptr_r <= {PW{1'b0}};
            wr_ptr_r <= {PW{1'b0}};
            cont_r   <= {CW{1'b0}};
            for (int i = 0; i < PROF; i++) begin
                mem_r[i] <= {LARG{1'b0}};
            end
        end else begin
            if (push_ef_s) begin
                mem_r[wr_ptr_r] <= dado_escrita;
                wr_ptr_r        <= wr_ptr_r + PW'(1);
            end else begin
                wr_ptr_r        <= wr_ptr_r;
            end
            if (pop_ef_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_ef_s, pop_ef_s})
                2'b10:   cont_r <= cont_r + CW'(1);
                2'b01:   cont_r <= cont_r - CW'(1);
                default: cont_r <= cont_r;
            endcase
        end
    end

endmodule

// File: rtl/decodifica_comandos.sv
// AstroGenius switch decoder: synchronise, debounce, validate and queue one command per press.
// Optional shot-cadence limiter enabled by defining DECODIFICA_COMANDOS_CADENCIA_EN.
module decodifica_comandos
    import astro_genius_pkg::*;
#(
    parameter int DEBOUNCE_CICLOS = 4,
    parameter int FIFO_PROF       = 4,
    parameter int CADENCIA_CICLOS = 1000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       habilita,
    input  logic [5:0] chaves,
    input  logic       comando_aceito,
    output logic       comando_valido,
    output logic       comando_tiro,
    output logic [2:0] comando_mira,
    output logic       erro_chaves,
    output logic       descartado,
    output logic       fifo_cheia,
    output logic [3:0] db_estado
);

    localparam int            DW     = $clog2(DEBOUNCE_CICLOS + 1);
    localparam logic [DW-1:0] DB_MAX = DW'(DEBOUNCE_CICLOS);
    localparam logic [DW-1:0] DB_PEN = DW'(DEBOUNCE_CICLOS - 1);

    logic [5:0]          sinc1_r;
    logic [5:0]          sinc2_r;
    logic [5:0]          padrao_r;
    logic [DW-1:0]       cont_r;
    estado_t             estado_r;
    logic                erro_r;
    logic                desc_r;

    logic                estavel_s;
    logic                chega_db_s;
    logic                captura_s;
    logic                valido_s;
    logic                push_s;
    logic                cad_desc_s;
    logic                fifo_desc_s;
    logic                fifo_vazia_s;
    comando_t            cmd_bruto_s;
    comando_t            cmd_s;
    logic [CMD_LARG-1:0] cabeca_s;

    assign estavel_s  = (sinc2_r == padrao_r);
    // "Reaching" the debounce count: the transition fires on the edge where the counter hits the limit.
    assign chega_db_s = estavel_s && (cont_r >= DB_PEN);
    assign captura_s  = (estado_r == CAPTURA);

    // Two-flop synchroniser, previous-sample register and saturating stability counter.
    always_ff @(posedge clock) begin
        if (!reset) begin
            sinc1_r  <= 6'd0;
            sinc2_r  <= 6'd0;
            padrao_r <= 6'd0;
            cont_r   <= {DW{1'b0}};
        end else begin
            sinc1_r  <= chaves;
            sinc2_r  <= sinc1_r;
            padrao_r <= sinc2_r;
            if (sinc2_r != padrao_r) begin
                cont_r <= {DW{1'b0}};
            end else if (cont_r < DB_MAX) begin
                cont_r <= cont_r + DW'(1);
            end else begin
                cont_r <= cont_r;
            end
        end
    end

    // Validate and encode the stable pattern held during CAPTURA.
    always_comb begin
        cmd_bruto_s.tiro = padrao_r[0];
        cmd_bruto_s.mira = indice_mira(padrao_r[5:1]);
        valido_s         = mira_valida(padrao_r[5:1]);
        push_s           = captura_s && valido_s;
    end

`ifdef DECODIFICA_COMANDOS_CADENCIA_EN
    localparam int CADW = $clog2(CADENCIA_CICLOS + 1);

    logic [CADW-1:0] cad_r;

    // Fire inside the cadence window is demoted to aim-only and flagged as a drop.
    always_comb begin
        cmd_s      = cmd_bruto_s;
        cad_desc_s = 1'b0;
        if ((cad_r != {CADW{1'b0}}) && cmd_bruto_s.tiro) begin
            cmd_s.tiro = 1'b0;
            cad_desc_s = push_s;
        end else begin
            cad_desc_s = 1'b0;
        end
    end

    // Cadence window: reloaded by every queued fire, counts down to zero.
    always_ff @(posedge clock) begin
        if (!reset) begin
            cad_r <= {CADW{1'b0}};
        end else if (push_s && cmd_s.tiro) begin
            cad_r <= CADW'(CADENCIA_CICLOS);
        end else if (cad_r != {CADW{1'b0}}) begin
            cad_r <= cad_r - CADW'(1);
        end else begin
            cad_r <= cad_r;
        end
    end
`else
    assign cmd_s      = cmd_bruto_s;
    assign cad_desc_s = 1'b0;
`endif

    fifo_comandos #(
        .PROF(FIFO_PROF),
        .LARG(CMD_LARG)
    ) u_fifo (
        .clock        (clock),
        .reset        (reset),
        .push         (push_s),
        .pop          (comando_aceito),
        .dado_escrita (cmd_s),
        .dado_leitura (cabeca_s),
        .cheia        (fifo_cheia),
        .vazia        (fifo_vazia_s),
        .descarte     (fifo_desc_s)
    );

    // Press FSM with registered error / drop pulses.
    always_ff @(posedge clock) begin
        if (!reset) begin
            estado_r <= OCIOSO;
            erro_r   <= 1'b0;
            desc_r   <= 1'b0;
        end else begin
            erro_r <= captura_s && !valido_s;
            desc_r <= fifo_desc_s || cad_desc_s;
            case (estado_r)
                OCIOSO: begin
                    if (habilita && (sinc2_r != 6'd0)) begin
                        estado_r <= ESTABILIZANDO;
                    end else begin
                        estado_r <= OCIOSO;
                    end
                end
                ESTABILIZANDO: begin
                    if (!estavel_s || (sinc2_r == 6'd0)) begin
                        estado_r <= OCIOSO;
                    end else if (!habilita) begin
                        estado_r <= ESPERA_SOLTURA;
                    end else if (chega_db_s) begin
                        estado_r <= CAPTURA;
                    end else begin
                        estado_r <= ESTABILIZANDO;
                    end
                end
                CAPTURA: begin
                    estado_r <= ESPERA_SOLTURA;
                end
                ESPERA_SOLTURA: begin
                    if ((sinc2_r == 6'd0) && chega_db_s) begin
                        estado_r <= OCIOSO;
                    end else begin
                        estado_r <= ESPERA_SOLTURA;
                    end
                end
                default: begin
                    estado_r <= OCIOSO;
                end
            endcase
        end
    end

    assign comando_valido = !fifo_vazia_s;
    assign comando_tiro   = cabeca_s[CMD_LARG-1];
    assign comando_mira   = cabeca_s[MIRA_LARG-1:0];
    assign erro_chaves    = erro_r;
    assign descartado     = desc_r;
    assign db_estado      = estado_r;

endmodule

// File: tb/tb_decodifica_comandos.sv
// Directed bench for decodifica_comandos at default parameters (cadence limiter not compiled in).
module tb_decodifica_comandos;

    logic       clock;
    logic       reset;
    logic       habilita;
    logic [5:0] chaves;
    logic       comando_aceito;
    logic       comando_valido;
    logic       comando_tiro;
    logic [2:0] comando_mira;
    logic       erro_chaves;
    logic       descartado;
    logic       fifo_cheia;
    logic [3:0] db_estado;

    int n_chk  = 0;
    int n_fail = 0;
    int n_erro = 0;
    int n_desc = 0;

    decodifica_comandos dut (
        .clock          (clock),
        .reset          (reset),
        .habilita       (habilita),
        .chaves         (chaves),
        .comando_aceito (comando_aceito),
        .comando_valido (comando_valido),
        .comando_tiro   (comando_tiro),
        .comando_mira   (comando_mira),
        .erro_chaves    (erro_chaves),
        .descartado     (descartado),
        .fifo_cheia     (fifo_cheia),
        .db_estado      (db_estado)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Pulse counters sampled mid-cycle.
    always @(negedge clock) begin
        if (erro_chaves === 1'b1) n_erro++;
        if (descartado === 1'b1) n_desc++;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic press(input logic [5:0] p, input int hold);
        chaves = p;
        tick(hold);
        chaves = 6'd0;
        tick(12);
    endtask

    task automatic pop_chk(input string tag, input logic t, input logic [2:0] m);
        chk({tag, "_valido"}, comando_valido, 8'd1);
        chk({tag, "_tiro"}, comando_tiro, t);
        chk({tag, "_mira"}, comando_mira, m);
        comando_aceito = 1'b1;
        tick(1);
        comando_aceito = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        habilita = 1'b1;
        chaves = 6'd0;
        comando_aceito = 1'b0;
        tick(5);
        chk("rst_valido", comando_valido, 8'd0);
        chk("rst_tiro", comando_tiro, 8'd0);
        chk("rst_mira", comando_mira, 8'd0);
        chk("rst_erro", erro_chaves, 8'd0);
        chk("rst_desc", descartado, 8'd0);
        chk("rst_cheia", fifo_cheia, 8'd0);
        chk("rst_estado", db_estado, 8'd0);
        reset = 1'b1;
        tick(1);

        // Press fire + aim 2; command appears 8 edges after the input changes.
        chaves = 6'b001001;
        tick(7);
        chk("lat_estado_captura", db_estado, 8'd2);
        chk("lat_valido_antes", comando_valido, 8'd0);
        tick(1);
        chk("lat_valido", comando_valido, 8'd1);
        chk("lat_tiro", comando_tiro, 8'd1);
        chk("lat_mira", comando_mira, 8'd2);
        chk("lat_estado_espera", db_estado, 8'd3);
        tick(2);
        chaves = 6'd0;
        tick(12);
        chk("lat_volta_ocioso", db_estado, 8'd0);
        chk("lat_sem_erro", n_erro, 8'd0);
        comando_aceito = 1'b1;
        tick(1);
        comando_aceito = 1'b0;
        chk("lat_pop_vazio", comando_valido, 8'd0);
        chk("lat_pop_mira", comando_mira, 8'd0);

        // Press too short to be accepted.
        press(6'b000101, 3);
        chk("curto_valido", comando_valido, 8'd0);
        chk("curto_estado", db_estado, 8'd0);

        // Multi-hot aim: one-cycle error pulse, nothing queued.
        chaves = 6'b000111;
        tick(7);
        chk("err_antes", erro_chaves, 8'd0);
        tick(1);
        chk("err_pulso", erro_chaves, 8'd1);
        tick(1);
        chk("err_fim", erro_chaves, 8'd0);
        tick(1);
        chaves = 6'd0;
        tick(12);
        chk("err_fifo", comando_valido, 8'd0);
        chk("err_contagem", n_erro, 8'd1);

        // Fire with no aim is also rejected.
        press(6'b000001, 10);
        chk("err_sem_mira", n_erro, 8'd2);
        chk("err_sem_mira_fifo", comando_valido, 8'd0);

        // Presses while disabled are ignored.
        habilita = 1'b0;
        press(6'b000101, 10);
        chk("desab_valido", comando_valido, 8'd0);
        chk("desab_erro", n_erro, 8'd2);
        chk("desab_estado", db_estado, 8'd0);
        habilita = 1'b1;

        // Fill the FIFO; the fifth press is dropped.
        repeat (4) press(6'b000101, 10);
        chk("cheio_flag", fifo_cheia, 8'd1);
        chk("cheio_sem_desc", n_desc, 8'd0);
        press(6'b000101, 10);
        chk("cheio_desc", n_desc, 8'd1);
        chk("cheio_flag2", fifo_cheia, 8'd1);
        for (int i = 0; i < 4; i++) pop_chk($sformatf("cheio_pop%0d", i), 1'b1, 3'd1);
        chk("cheio_esvaziado", comando_valido, 8'd0);
        chk("cheio_flag_baixo", fifo_cheia, 8'd0);

        // Distinct entries, then push into a full FIFO with a simultaneous pop.
        press(6'b000010, 10);
        press(6'b000100, 10);
        press(6'b001000, 10);
        press(6'b010001, 10);
        chk("dist_cabeca_mira", comando_mira, 8'd0);
        chk("dist_cabeca_tiro", comando_tiro, 8'd0);
        chaves = 6'b100000;
        tick(7);
        comando_aceito = 1'b1;
        tick(1);
        comando_aceito = 1'b0;
        chk("simul_cheia", fifo_cheia, 8'd1);
        chk("simul_mira", comando_mira, 8'd1);
        tick(2);
        chaves = 6'd0;
        tick(12);
        chk("simul_sem_desc", n_desc, 8'd1);
        pop_chk("simul_pop1", 1'b0, 3'd1);
        pop_chk("simul_pop2", 1'b0, 3'd2);
        pop_chk("simul_pop3", 1'b1, 3'd3);
        pop_chk("simul_pop4", 1'b0, 3'd4);
        chk("simul_vazio", comando_valido, 8'd0);

        // Accept while empty must not disturb the count.
        comando_aceito = 1'b1;
        tick(1);
        comando_aceito = 1'b0;
        press(6'b000011, 10);
        chk("aceito_vazio_valido", comando_valido, 8'd1);
        chk("aceito_vazio_cheia", fifo_cheia, 8'd0);
        chk("aceito_vazio_mira", comando_mira, 8'd0);
        chk("aceito_vazio_tiro", comando_tiro, 8'd1);

        // Reset with a queued command empties the FIFO.
        reset = 1'b0;
        tick(1);
        reset = 1'b1;
        chk("rst2_valido", comando_valido, 8'd0);
        chk("rst2_tiro", comando_tiro, 8'd0);
        chk("rst2_estado", db_estado, 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
